// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller: funct3 decode, alignment check, memory port sequencing
module lsu_ctrl #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause,
  output logic [31:0] rsp_badaddr,
  output logic        mem_clk_enable,
  output logic        mem_r_en,
  output logic [31:0] mem_r_addr,
  output logic [1:0]  mem_r_mode,
  input  logic [31:0] mem_r_data,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [1:0]  mem_w_mode,
  input  logic [1:0]  mem_state
);

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD, S_RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        uns_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [1:0]  rsp_cause_q;
  logic [31:0] rsp_badaddr_q;
  logic        mem_r_en_q;
  logic [31:0] mem_r_addr_q;
  logic [1:0]  mem_r_mode_q;
  logic        mem_w_en_q;
  logic [31:0] mem_w_addr_q;
  logic [31:0] mem_w_data_q;
  logic [1:0]  mem_w_mode_q;

  logic        illegal;
  logic        misaligned;
  logic [31:0] ext_data;

  // Request decode: reserved funct3 codes and unsigned stores are illegal; halves/words must be naturally aligned
  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                 (req_we && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Sign/zero extension of right-aligned read data according to the latched access size
  always_comb begin
    ext_data = mem_r_data;
    case (mem_r_mode_q)
      2'b00:   ext_data = {{24{~uns_q & mem_r_data[7]}}, mem_r_data[7:0]};
      2'b01:   ext_data = {{16{~uns_q & mem_r_data[15]}}, mem_r_data[15:0]};
      default: ext_data = mem_r_data;
    endcase
  end

  // Controller FSM; every output is registered and all state freezes while clk_enable is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      uns_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
      rsp_cause_q   <= 2'd0;
      rsp_badaddr_q <= 32'd0;
      mem_r_en_q    <= 1'b0;
      mem_r_addr_q  <= 32'd0;
      mem_r_mode_q  <= 2'd0;
      mem_w_en_q    <= 1'b0;
      mem_w_addr_q  <= 32'd0;
      mem_w_data_q  <= 32'd0;
      mem_w_mode_q  <= 2'd0;
    end else if (clk_enable) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            uns_q       <= req_funct3[2];
            if (illegal || misaligned) begin
              // Error responses skip the memory entirely and appear one cycle after acceptance
              state_q       <= S_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_cause_q   <= illegal ? 2'd2 : 2'd1;
              rsp_badaddr_q <= req_addr;
              rsp_rdata_q   <= 32'd0;
            end else if (req_we) begin
              state_q      <= S_STORE;
              mem_w_en_q   <= 1'b1;
              mem_w_addr_q <= req_addr;
              mem_w_data_q <= req_wdata;
              mem_w_mode_q <= req_funct3[1:0];
            end else begin
              state_q      <= S_LOAD;
              cnt_q        <= 3'd0;
              mem_r_en_q   <= 1'b1;
              mem_r_addr_q <= req_addr;
              mem_r_mode_q <= req_funct3[1:0];
            end
          end
        end
        S_STORE: begin
          state_q       <= S_RESP;
          mem_w_en_q    <= 1'b0;
          mem_w_addr_q  <= 32'd0;
          mem_w_data_q  <= 32'd0;
          mem_w_mode_q  <= 2'd0;
          rsp_valid_q   <= 1'b1;
          rsp_err_q     <= 1'b0;
          rsp_cause_q   <= 2'd0;
          rsp_badaddr_q <= 32'd0;
          rsp_rdata_q   <= 32'd0;
        end
        S_LOAD: begin
          // Strobe lasts one enabled cycle; address/mode stay put until the data is captured
          mem_r_en_q <= 1'b0;
          if (cnt_q == LAT) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            mem_r_addr_q <= 32'd0;
            mem_r_mode_q <= 2'd0;
            if (mem_state != 2'd0) begin
              rsp_err_q     <= 1'b1;
              rsp_cause_q   <= 2'd3;
              rsp_badaddr_q <= mem_r_addr_q;
              rsp_rdata_q   <= 32'd0;
            end else begin
              rsp_err_q     <= 1'b0;
              rsp_cause_q   <= 2'd0;
              rsp_badaddr_q <= 32'd0;
              rsp_rdata_q   <= ext_data;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_cause_q   <= 2'd0;
            rsp_badaddr_q <= 32'd0;
            rsp_rdata_q   <= 32'd0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_clk_enable = clk_enable;
  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_cause      = rsp_cause_q;
  assign rsp_badaddr    = rsp_badaddr_q;
  assign mem_r_en       = mem_r_en_q;
  assign mem_r_addr     = mem_r_addr_q;
  assign mem_r_mode     = mem_r_mode_q;
  assign mem_w_en       = mem_w_en_q;
  assign mem_w_addr     = mem_w_addr_q;
  assign mem_w_data     = mem_w_data_q;
  assign mem_w_mode     = mem_w_mode_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit controller that sits directly upstream of the byte-addressable memory interface. It accepts one load or store request at a time from the core pipeline over a valid/ready handshake. It decodes RISC-V funct3, pre-checks alignment, and drives the memory port. For loads it waits out the read latency, sign- or zero-extends the returned data, and returns a response with error status.

Parameters:
READ_LATENCY, 1, cycles from the mem_r_en issue cycle to valid mem_r_data; legal range 1..7.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clk_enable  in  1  global stall; 0 freezes all state; forwarded to mem_clk_enable
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_funct3  in  3  RISC-V funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  request failed
rsp_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 memory error
rsp_badaddr  out  32  req_addr of the failed request; 0 otherwise
mem_clk_enable  out  1  equals clk_enable
mem_r_en  out  1  read strobe
mem_r_addr  out  32  read address
mem_r_mode  out  2  00 byte, 01 half, 10 word
mem_r_data  in  32  zero-extended read data from memory
mem_w_en  out  1  write strobe
mem_w_addr  out  32  write address
mem_w_data  out  32  write data, right-aligned
mem_w_mode  out  2  00 byte, 01 half, 10 word
mem_state  in  2  memory status; nonzero = error

Behaviour:
- Reset (rst_n=0 at a clk edge, takes priority over clk_enable):
  - FSM to IDLE; any outstanding request is dropped with no response.
  - All outputs 0 except req_ready=1 and mem_clk_enable=clk_enable.
- State changes happen only on edges where clk_enable=1.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, wdata, we and funct3, then decode.
  - Mode = funct3[1:0]; unsigned flag = funct3[2].
  - Illegal funct3: 011, 110, 111, or any store with funct3[2]=1 -> ERR, cause 2.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 -> ERR, cause 1.
  - Misaligned or illegal requests never assert mem_r_en or mem_w_en.
  - Otherwise: store -> STORE; load -> LOAD.
- STORE (1 cycle):
  - mem_w_en=1 with latched addr, wdata and mode.
  - Next state RESP with rdata=0, err=0.
- LOAD:
  - mem_r_en=1 for exactly the first cycle only.
  - mem_r_addr and mem_r_mode are held stable from the issue cycle until capture, because the memory's read mux depends on them combinationally.
  - A wait counter counts READ_LATENCY cycles, then captures mem_r_data and mem_state.
  - If mem_state!=0: cause 3, badaddr=addr, rdata=0.
  - Else byte: signed replicates bit7, unsigned zero-fills [31:8].
  - Else half: signed replicates bit15, unsigned zero-fills [31:16].
  - Else word: data passes through.
  - Next state RESP.
- ERR: load response fields, go to RESP (response appears 1 cycle after acceptance).
- RESP:
  - rsp_valid=1; all rsp_* fields are held stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE.
  - req_ready=0 in every state except IDLE; no pipelining, so at most one request is outstanding.
  - rsp_valid and req_ready are never both 1.
- Store completes with no memory status check; memory errors are reported on loads only.
- Latency, request accept to rsp_valid, with rsp_ready held at 1:
  - store: 2 cycles
  - load: 2+READ_LATENCY cycles
  - error: 1 cycle
- clk_enable=0 mid-operation: the counter and FSM freeze; strobes stay at their current level, so the issue cycle is extended.
- mem_* address, data and mode outputs are 0 whenever the FSM is in IDLE.

Test Plan:
- Store word at 0x100, data 0xDEADBEEF, then LW 0x100 -> mem_w_en for 1 cycle with mode 10; load rsp_rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after accept (READ_LATENCY=1).
- Memory word 0x000080F0 at 0x200: LB 0x200 -> 0xFFFFFFF0; LBU 0x200 -> 0x000000F0; LH 0x200 -> 0xFFFF80F0; LHU 0x200 -> 0x000080F0.
- LW 0x102 and SH 0x101 -> rsp_err=1, cause=1, badaddr=0x102 and 0x101 respectively; mem_r_en and mem_w_en never asserted.
- funct3=011 load, and funct3=100 store -> cause=2, no memory strobe.
- Force mem_state=01 during a load capture -> cause=3, rdata=0; hold rsp_ready=0 for 5 cycles -> response fields stable and req_ready=0 throughout.
- Assert rst_n=0 during LOAD wait with READ_LATENCY=3 -> next cycle IDLE, rsp_valid=0, req_ready=1; a subsequent LW completes normally.
